sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port among NUM_PORTS requesters (instruction fetch, data port, UART/DMA) inside the FullSystemTop fabric.
- Grants one transaction at a time using round-robin, with an optional lock for atomic read-modify-write sequences.
- Routes the controller's response back to the issuing port.
- Controller sees exactly one outstanding command at any time.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8)
- ADDR_W, 24, SDRAM word-address width
- DATA_W, 64, data width on the controller side
- LOCK_TIMEOUT, 64, idle cycles before a held lock is forcibly released (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port accept, one-hot or zero
- req_write  in  NUM_PORTS  1=write, 0=read
- req_lock  in  NUM_PORTS  keep the grant after this transaction
- req_addr  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  packed write data
- req_wmask  in  NUM_PORTS*(DATA_W/8)  packed byte enables
- resp_valid  out  NUM_PORTS  one-hot single-cycle response pulse
- resp_rdata  out  DATA_W  read data, shared by all ports, qualified by resp_valid
- ctl_cmd_valid  out  1  command to the controller
- ctl_cmd_ready  in  1  controller accepts the command
- ctl_cmd_write, ctl_cmd_addr, ctl_cmd_wdata, ctl_cmd_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched command fields
- ctl_resp_valid  in  1  controller completion (reads and writes)
- ctl_resp_rdata  in  DATA_W  controller read data
- grant_id  out  $clog2(NUM_PORTS)  currently or last granted port
- busy  out  1  transaction in flight

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - req_ready=0, resp_valid=0, ctl_cmd_valid=0, busy=0
  - resp_rdata=0, ctl_cmd_* =0, grant_id=0
  - rr_ptr=0, lock_active=0, lock timer=0
  - FSM=IDLE
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, winner selection:
  - If lock_active: only lock_owner is eligible.
  - Otherwise: the first port with req_valid set, searching from rr_ptr upward modulo NUM_PORTS.
- IDLE, acceptance:
  - req_ready[winner] is asserted combinationally in the same cycle; the handshake is req_valid & req_ready.
  - On handshake: latch write/addr/wdata/wmask into ctl_cmd_*, set grant_id=winner, set rr_ptr=(winner+1) mod NUM_PORTS, go to ISSUE.
- ISSUE:
  - ctl_cmd_valid=1, with fields held stable until ctl_cmd_ready.
  - On ctl_cmd_ready: go to WAIT. Zero-wait accept gives ISSUE lasting 1 cycle.
- WAIT:
  - On ctl_resp_valid: register resp_rdata=ctl_resp_rdata and pulse resp_valid[grant_id] for exactly 1 cycle (the next cycle), then go to IDLE.
  - ctl_resp_valid outside WAIT is ignored.
- Timing:
  - busy=1 in ISSUE and WAIT.
  - req_ready is never asserted outside IDLE.
  - Back-to-back latency: minimum 3 cycles from one acceptance to the next.
- Lock:
  - On a handshake with req_lock[winner]=1: set lock_active=1, lock_owner=winner.
  - On a handshake by lock_owner with req_lock=0: clear lock_active.
  - While lock_active, the timer counts cycles spent in IDLE with req_valid[lock_owner]=0. It resets to 0 on any owner handshake.
  - When the timer reaches LOCK_TIMEOUT: clear lock_active. Normal round-robin resumes next cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid high and are served in rotation. No port waits more than NUM_PORTS-1 foreign transactions unless a lock is held.
- rr_ptr wrap: the value NUM_PORTS-1 increments to 0.
- Reset mid-transaction: all state clears immediately and ctl_cmd_valid drops asynchronously. The controller shares the reset, so the in-flight command is abandoned and no resp_valid is produced.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT)
  - function for the port-index width
  - DATA_W/8 mask-width localparam helper
- One sub-module, rr_arbiter_core: combinational rotate-priority pick (req vector, rr_ptr, lock_active, lock_owner -> winner, any).
- All registers live in sdram_port_arbiter.

Test Plan:
- Single read, zero-wait: port 1 read addr 0x000100, ctl_cmd_ready=1, ctl_resp_valid 4 cycles later with rdata 0xDEADBEEF_00000001 -> req_ready[1] for 1 cycle; ctl_cmd_addr=0x000100; resp_valid=3'b010 one cycle after ctl_resp_valid with the matching rdata.
- Contention: ports 0, 1, 2 hold req_valid continuously, rr_ptr=0 -> grant order 0,1,2,0; each port gets exactly one resp_valid per round.
- Backpressure: ctl_cmd_ready low for 5 cycles -> ctl_cmd_valid held with stable addr/wdata/wmask for 6 cycles; no req_ready anywhere.
- Lock: port 2 issues a locked read then an unlocked write, while port 0 requests throughout -> port 0 is not granted until port 2's write completes; then grant goes to port 0.
- Lock timeout with LOCK_TIMEOUT=4: port 1 issues a locked access and then goes idle, port 0 requesting -> port 0 is granted in the cycle after 4 idle cycles.
- Async reset asserted in WAIT -> ctl_cmd_valid=0, busy=0, grant_id=0 before the next clock edge; no resp_valid after release; the first post-reset grant starts from port 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and width helpers for the SDRAM command-port arbiter.
// The FSM encoding here is also what appears on the debug state output.
package sdram_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int mask_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational rotate-priority pick: the first requester at or above rr_ptr
// wins, or only the lock owner when a lock is held.
module rr_arbiter_core
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  input  logic                 lock_active_i,
  input  logic [IDX_W-1:0]     lock_owner_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic                 any_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is the last one written.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    sum      = '0;
    cand     = '0;
    if (lock_active_i) begin
      winner_o = lock_owner_i;
      any_o    = req_i[lock_owner_i];
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        sum = {1'b0, rr_ptr_i} + (IDX_W + 1)'(i);
        if (sum >= (IDX_W + 1)'(NUM_PORTS)) sum = sum - (IDX_W + 1)'(NUM_PORTS);
        cand = sum[IDX_W-1:0];
        if (req_i[cand]) begin
          winner_o = cand;
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port among NUM_PORTS requesters, one
// transaction in flight at a time, round-robin with an optional timed lock.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 64,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0]                   req_valid,
  output logic [NUM_PORTS-1:0]                   req_ready,
  input  logic [NUM_PORTS-1:0]                   req_write,
  input  logic [NUM_PORTS-1:0]                   req_lock,
  input  logic [NUM_PORTS*ADDR_W-1:0]            req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]            req_wdata,
  input  logic [NUM_PORTS*mask_width(DATA_W)-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]                   resp_valid,
  output logic [DATA_W-1:0]                      resp_rdata,
  output logic                                   ctl_cmd_valid,
  input  logic                                   ctl_cmd_ready,
  output logic                                   ctl_cmd_write,
  output logic [ADDR_W-1:0]                      ctl_cmd_addr,
  output logic [DATA_W-1:0]                      ctl_cmd_wdata,
  output logic [mask_width(DATA_W)-1:0]          ctl_cmd_wmask,
  input  logic                                   ctl_resp_valid,
  input  logic [DATA_W-1:0]                      ctl_resp_rdata,
  output logic [idx_width(NUM_PORTS)-1:0]        grant_id,
  output logic                                   busy,
  output logic [1:0]                             dbg_state
);

  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam int MASK_W = mask_width(DATA_W);
  localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);

  // Handshake: a request transfers in the IDLE cycle where req_valid[i] & req_ready[i];
  // the controller command transfers on ctl_cmd_valid & ctl_cmd_ready.
  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d, grant_id_q, lock_owner_q, winner;
  logic                lock_active_q, any_req, handshake, owner_idle;
  logic [TMR_W-1:0]    lock_timer_q;
  logic                cmd_valid_q, cmd_write_q, busy_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q, resp_rdata_q;
  logic [MASK_W-1:0]   cmd_wmask_q;
  logic [NUM_PORTS-1:0] resp_valid_q, grant_onehot;

  rr_arbiter_core #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_core (
    .req_i        (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .lock_active_i(lock_active_q),
    .lock_owner_i (lock_owner_q),
    .winner_o     (winner),
    .any_o        (any_req)
  );

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && any_req) req_ready[winner] = 1'b1;
  end

  always_comb begin
    grant_onehot             = '0;
    grant_onehot[grant_id_q] = 1'b1;
  end

  assign handshake  = |(req_valid & req_ready);
  assign rr_ptr_d   = (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
  assign owner_idle = lock_active_q && (state_q == ST_IDLE) && !req_valid[lock_owner_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      lock_owner_q  <= '0;
      lock_active_q <= 1'b0;
      lock_timer_q  <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_wmask_q   <= '0;
      busy_q        <= 1'b0;
      resp_valid_q  <= '0;
      resp_rdata_q  <= '0;
    end else begin
      resp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            cmd_write_q  <= req_write[winner];
            cmd_addr_q   <= req_addr[winner*ADDR_W +: ADDR_W];
            cmd_wdata_q  <= req_wdata[winner*DATA_W +: DATA_W];
            cmd_wmask_q  <= req_wmask[winner*MASK_W +: MASK_W];
            cmd_valid_q  <= 1'b1;
            busy_q       <= 1'b1;
            grant_id_q   <= winner;
            rr_ptr_q     <= rr_ptr_d;
            lock_timer_q <= '0;
            state_q      <= ST_ISSUE;
            if (req_lock[winner]) begin
              lock_active_q <= 1'b1;
              lock_owner_q  <= winner;
            end else if (lock_active_q && winner == lock_owner_q) begin
              lock_active_q <= 1'b0;
            end
          end else if (owner_idle) begin
            // An owner that stays quiet too long forfeits the lock.
            if (lock_timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
              lock_active_q <= 1'b0;
              lock_timer_q  <= '0;
            end else begin
              lock_timer_q <= lock_timer_q + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (ctl_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ctl_resp_valid) begin
            resp_valid_q <= grant_onehot;
            resp_rdata_q <= ctl_resp_rdata;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign ctl_cmd_valid = cmd_valid_q;
  assign ctl_cmd_write = cmd_write_q;
  assign ctl_cmd_addr  = cmd_addr_q;
  assign ctl_cmd_wdata = cmd_wdata_q;
  assign ctl_cmd_wmask = cmd_wmask_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single read, contention, backpressure,
// lock, lock timeout and asynchronous reset in flight.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic         clock, reset;
  logic [2:0]   req_valid, req_ready, req_write, req_lock, resp_valid;
  logic [71:0]  req_addr;
  logic [191:0] req_wdata;
  logic [23:0]  req_wmask;
  logic [63:0]  resp_rdata, ctl_cmd_wdata, ctl_resp_rdata;
  logic         ctl_cmd_valid, ctl_cmd_ready, ctl_cmd_write, ctl_resp_valid, busy;
  logic [23:0]  ctl_cmd_addr;
  logic [7:0]   ctl_cmd_wmask;
  logic [1:0]   grant_id, dbg_state;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q[$];

  sdram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(24), .DATA_W(64), .LOCK_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready), .ctl_cmd_write(ctl_cmd_write),
    .ctl_cmd_addr(ctl_cmd_addr), .ctl_cmd_wdata(ctl_cmd_wdata), .ctl_cmd_wmask(ctl_cmd_wmask),
    .ctl_resp_valid(ctl_resp_valid), .ctl_resp_rdata(ctl_resp_rdata),
    .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    settle();
    reset = 1'b0;
  endtask

  function automatic logic [1:0] oh_idx(input logic [2:0] v);
    oh_idx = 2'd3;
    for (int i = 0; i < 3; i++) if (v[i]) oh_idx = 2'(i);
  endfunction

  logic [2:0]  lock_tab [3];
  logic [2:0]  tmo_tab [7];
  int          rcnt [3];
  int          n, last_cyc;
  logic [1:0]  e, g;
  logic        pend;
  logic [23:0] exp_addr;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    ctl_cmd_ready = 1'b0; ctl_resp_valid = 1'b0; ctl_resp_rdata = '0;

    // reset state
    #3;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_cmd_valid", 64'(ctl_cmd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_cmd_addr", 64'(ctl_cmd_addr), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    step();
    reset = 1'b0;

    // single read, zero-wait accept
    req_valid = 3'b010; req_write = 3'b000;
    req_addr[24 +: 24] = 24'h000100;
    ctl_cmd_ready = 1'b1;
    settle();
    check("single_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    settle();
    check("single_cmd_valid", 64'(ctl_cmd_valid), 64'd1);
    check("single_cmd_addr", 64'(ctl_cmd_addr), 64'h000100);
    check("single_cmd_write", 64'(ctl_cmd_write), 64'd0);
    check("single_ready_drop", 64'(req_ready), 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    check("single_grant", 64'(grant_id), 64'd1);
    step();
    settle();
    check("single_issue_1cyc", 64'(ctl_cmd_valid), 64'd0);
    check("single_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    step();
    step();
    ctl_resp_valid = 1'b1; ctl_resp_rdata = 64'hDEADBEEF_00000001;
    step();
    ctl_resp_valid = 1'b0;
    settle();
    check("single_resp_valid", 64'(resp_valid), 64'b010);
    check("single_resp_rdata", resp_rdata, 64'hDEADBEEF_00000001);
    check("single_busy_clear", 64'(busy), 64'd0);
    step();
    check("single_resp_pulse", 64'(resp_valid), 64'd0);

    // contention: all three request continuously from rr_ptr=0
    pulse_reset();
    for (int i = 0; i < 3; i++) req_addr[i*24 +: 24] = 24'h000010 + 24'(i);
    req_valid = 3'b111; ctl_cmd_ready = 1'b1;
    ctl_resp_valid = 1'b1; ctl_resp_rdata = 64'h1111_2222_3333_4444;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
    rcnt = '{0, 0, 0};
    n = 0; last_cyc = 0; pend = 1'b0; exp_addr = '0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      settle();
      if (pend) begin check("contention_addr", 64'(ctl_cmd_addr), 64'(exp_addr)); pend = 1'b0; end
      for (int p = 0; p < 3; p++) if (resp_valid[p]) rcnt[p]++;
      if (resp_valid != 3'b000) check("contention_rdata", resp_rdata, 64'h1111_2222_3333_4444);
      if (req_ready != 3'b000) begin
        e = exp_q.pop_front();
        g = oh_idx(req_ready);
        check("contention_grant", 64'(g), 64'(e));
        if (n > 0) check("contention_gap", 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        exp_addr = 24'h000010 + 24'(e);
        pend = 1'b1;
        n++;
      end
      @(posedge clock);
      #1;
    end
    req_valid = '0;
    check("contention_grants", 64'(n), 64'd4);
    for (int k = 0; k < 6; k++) begin
      settle();
      if (pend) begin check("contention_addr", 64'(ctl_cmd_addr), 64'(exp_addr)); pend = 1'b0; end
      for (int p = 0; p < 3; p++) if (resp_valid[p]) rcnt[p]++;
      step();
    end
    ctl_resp_valid = 1'b0;
    check("contention_resp0", 64'(rcnt[0]), 64'd2);
    check("contention_resp1", 64'(rcnt[1]), 64'd1);
    check("contention_resp2", 64'(rcnt[2]), 64'd1);

    // backpressure: command held six cycles, fields stable
    req_valid = 3'b001; req_write = 3'b001;
    req_addr[0 +: 24] = 24'h00ABCD; req_wdata[0 +: 64] = 64'hCAFE_F00D_1234_5678;
    req_wmask[0 +: 8] = 8'h0F; ctl_cmd_ready = 1'b0;
    settle();
    check("bp_ready", 64'(req_ready), 64'b001);
    step();
    req_addr[0 +: 24] = 24'h3FFFFF; req_wdata[0 +: 64] = '1; req_wmask[0 +: 8] = 8'hFF;
    req_valid = 3'b010;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ctl_cmd_ready = 1'b1;
      settle();
      check("bp_cmd_valid", 64'(ctl_cmd_valid), 64'd1);
      check("bp_cmd_addr", 64'(ctl_cmd_addr), 64'h00ABCD);
      check("bp_cmd_wdata", ctl_cmd_wdata, 64'hCAFE_F00D_1234_5678);
      check("bp_cmd_wmask", 64'(ctl_cmd_wmask), 64'h0F);
      check("bp_cmd_write", 64'(ctl_cmd_write), 64'd1);
      check("bp_no_ready", 64'(req_ready), 64'd0);
      step();
    end
    settle();
    check("bp_cmd_drop", 64'(ctl_cmd_valid), 64'd0);
    check("bp_wait_no_ready", 64'(req_ready), 64'd0);
    req_valid = '0; ctl_resp_valid = 1'b1;
    step();
    ctl_resp_valid = 1'b0;
    settle();
    check("bp_resp", 64'(resp_valid), 64'b001);

    // lock: port 2 locked read, then unlocked write, port 0 waiting throughout
    pulse_reset();
    req_write = '0; req_lock = 3'b100; req_valid = 3'b100;
    req_addr[48 +: 24] = 24'h000200;
    ctl_cmd_ready = 1'b1; ctl_resp_valid = 1'b1;
    settle();
    check("lock_first_ready", 64'(req_ready), 64'b100);
    step();
    req_valid = 3'b101; req_lock = 3'b000; req_write = 3'b100;
    lock_tab = '{3'b000, 3'b000, 3'b100};
    for (int k = 0; k < 3; k++) begin
      settle();
      check("lock_held_ready", 64'(req_ready), 64'(lock_tab[k]));
      step();
    end
    req_valid = 3'b001; req_write = 3'b000;
    lock_tab = '{3'b000, 3'b000, 3'b001};
    for (int k = 0; k < 3; k++) begin
      settle();
      check("lock_release_ready", 64'(req_ready), 64'(lock_tab[k]));
      if (k == 2) check("lock_write_resp", 64'(resp_valid), 64'b100);
      step();
    end
    req_valid = '0;
    step(); step(); step();
    ctl_resp_valid = 1'b0;

    // lock timeout: port 1 locks then goes quiet
    pulse_reset();
    req_valid = 3'b010; req_lock = 3'b010;
    ctl_cmd_ready = 1'b1; ctl_resp_valid = 1'b1;
    settle();
    check("tmo_lock_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = 3'b001; req_lock = 3'b000;
    tmo_tab = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    for (int k = 0; k < 7; k++) begin
      settle();
      check("tmo_ready", 64'(req_ready), 64'(tmo_tab[k]));
      step();
    end
    req_valid = '0;
    step(); step(); step();
    ctl_resp_valid = 1'b0;

    // asynchronous reset while waiting for the controller
    req_valid = 3'b010;
    step();
    req_valid = '0;
    step();
    settle();
    check("arst_pre_state", 64'(dbg_state), 64'(ST_WAIT));
    check("arst_pre_grant", 64'(grant_id), 64'd1);
    reset = 1'b1;
    ctl_resp_valid = 1'b1;
    settle();
    check("arst_cmd_valid", 64'(ctl_cmd_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_grant", 64'(grant_id), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("arst_no_resp", 64'(resp_valid), 64'd0);
      step();
    end
    ctl_resp_valid = 1'b0; ctl_cmd_ready = 1'b0;
    req_valid = 3'b111;
    settle();
    check("arst_first_grant", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    settle();
    check("arst_issue_valid", 64'(ctl_cmd_valid), 64'd1);
    reset = 1'b1;
    settle();
    check("arst_issue_drop", 64'(ctl_cmd_valid), 64'd0);
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
